// File: rtl/uart_gram_tx.sv
// uart_gram_tx: reads GRAM character cells and sends each as an 8N1 char/addr-lo/addr-hi frame
module uart_gram_tx #(
  parameter int clk_hz = 50_000_000,
  parameter int bps = 115_200,
  parameter int CLKS_PER_BIT = clk_hz / bps
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] start_address,
  input  logic [12:0] count,
  output logic [11:0] gram_read_address,
  output logic        gram_read_enable,
  input  logic [6:0]  gram_read_data,
  output logic        txd,
  output logic        busy,
  output logic        done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [2:0] {IDLE, READ, WAIT, LOAD, SEND, NEXT} state_t;
  state_t state;
  logic [11:0] addr;
  logic [12:0] remaining;
  logic [CW-1:0] baud;
  logic [3:0] bit_idx;
  logic [1:0] byte_idx;
  logic [6:0] char_q;
  logic [23:0] frame;
  // Sequencer: fetch a cell, build its 3-byte frame, shift it out LSB first, advance
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      remaining <= '0;
      baud <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      char_q <= '0;
      frame <= '0;
      gram_read_address <= '0;
      gram_read_enable <= 1'b0;
      txd <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      gram_read_enable <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (count != '0) begin
            addr <= start_address;
            remaining <= count;
            busy <= 1'b1;
            gram_read_address <= start_address;
            gram_read_enable <= 1'b1;
            state <= READ;
          end else done <= 1'b1;
        end
        READ: state <= WAIT;
        // read data is only valid in the cycle after the strobe, so capture it here
        WAIT: begin
          char_q <= gram_read_data;
          state <= LOAD;
        end
        LOAD: begin
          frame <= {4'b0, addr[11:8], addr[7:0], 1'b0, char_q};
          byte_idx <= '0;
          bit_idx <= '0;
          baud <= '0;
          txd <= 1'b0;
          state <= SEND;
        end
        SEND: if (baud == CW'(CLKS_PER_BIT - 1)) begin
          baud <= '0;
          if (bit_idx == 4'd9) begin
            if (byte_idx == 2'd2) state <= NEXT;
            else begin
              byte_idx <= byte_idx + 1'b1;
              frame <= {8'b0, frame[23:8]};
              bit_idx <= '0;
              txd <= 1'b0;
            end
          end else begin
            bit_idx <= bit_idx + 1'b1;
            txd <= bit_idx == 4'd8 ? 1'b1 : frame[bit_idx[2:0]];
          end
        end else baud <= baud + 1'b1;
        NEXT: begin
          remaining <= remaining - 1'b1;
          addr <= addr + 1'b1;
          if (remaining == 13'd1) begin
            done <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end else begin
            gram_read_address <= addr + 1'b1;
            gram_read_enable <= 1'b1;
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_gram_tx.sv
// tb_uart_gram_tx: scoreboard bench decoding txd and checking reads, framing, gaps and done timing
module tb_uart_gram_tx;
  localparam int CPB = 4;
  logic clk = 0, rst = 1, start = 0;
  logic [11:0] start_address = '0;
  logic [12:0] count = '0;
  logic [11:0] gram_read_address;
  logic gram_read_enable;
  logic [6:0] gram_read_data;
  logic txd, busy, done;
  logic [6:0] mem [4096];
  typedef struct {logic [7:0] b; int gap;} ent_t;
  ent_t exp_tx[$];
  logic [11:0] exp_rd[$];
  int checks = 0, failures = 0, cyc = 0, t_start = 0, ndone = 0;
  bit rx_abort = 0;

  uart_gram_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .start(start), .start_address(start_address), .count(count),
    .gram_read_address(gram_read_address), .gram_read_enable(gram_read_enable),
    .gram_read_data(gram_read_data), .txd(txd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // GRAM read port: data valid only in the cycle after the strobe
  always @(posedge clk) gram_read_data <= gram_read_enable ? mem[gram_read_address] : 7'h5A;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  // Read and done monitor
  always @(negedge clk) begin
    if (gram_read_enable) begin
      chk("read_pending", 32'(exp_rd.size() != 0), 1);
      if (exp_rd.size() != 0) chk("read_addr", gram_read_address, exp_rd.pop_front());
    end
    if (done) begin
      ndone++;
      chk("busy_at_done", busy, 0);
    end
  end

  // Serial receiver: each bit must hold for exactly CPB samples
  initial begin : rx
    int idle, at;
    logic [9:0] bits;
    bit steady;
    ent_t e;
    idle = 0;
    forever begin
      @(negedge clk);
      if (txd !== 1'b0) idle++;
      else begin
        at = cyc;
        steady = 1;
        bits = '0;
        for (int k = 1; k < CPB; k++) begin
          @(negedge clk);
          if (txd !== 1'b0) steady = 0;
        end
        for (int b = 1; b < 10; b++)
          for (int k = 0; k < CPB; k++) begin
            @(negedge clk);
            if (k == 0) bits[b] = txd;
            else if (txd !== bits[b]) steady = 0;
          end
        if (rx_abort) rx_abort = 0;
        else begin
          chk("rx_bit_timing", steady, 1);
          chk("rx_stop_bit", bits[9], 1);
          chk("rx_pending", 32'(exp_tx.size() != 0), 1);
          if (exp_tx.size() != 0) begin
            e = exp_tx.pop_front();
            chk("rx_byte", bits[8:1], e.b);
            if (e.gap == -2) chk("rx_latency", at - t_start, 3);
            else chk("rx_gap", idle, e.gap);
          end
        end
        idle = 0;
      end
    end
  end

  task automatic run(input logic [11:0] sa, input logic [12:0] n, input int poke_at);
    int k;
    logic [11:0] a;
    for (int i = 0; i < int'(n); i++) begin
      a = sa + 12'(i);
      exp_rd.push_back(a);
      exp_tx.push_back('{{1'b0, mem[a]}, (i == 0) ? -2 : 4});
      exp_tx.push_back('{a[7:0], 0});
      exp_tx.push_back('{{4'b0, a[11:8]}, 0});
    end
    @(negedge clk);
    start_address = sa;
    count = n;
    start = 1;
    @(negedge clk);
    start = 0;
    t_start = cyc;
    chk("busy_after_start", busy, 32'(n != 0));
    chk("rd_en_after_start", gram_read_enable, 32'(n != 0));
    k = 0;
    while (!done && k < int'(n) * 130 + 20) begin
      @(negedge clk);
      k++;
      start = (k == poke_at);
      if (k == poke_at) begin
        start_address = 12'h555;
        count = 13'd7;
      end
    end
    start = 0;
    chk("done_latency", k, 124 * int'(n));
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("busy_idle", busy, 0);
    chk("tx_drained", exp_tx.size(), 0);
    chk("rd_drained", exp_rd.size(), 0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int nd;
    for (int i = 0; i < 4096; i++) mem[i] = 7'(i * 37 + 5);
    mem[12'h123] = 7'h41;
    mem[12'hFFF] = 7'h7F;
    mem[12'h000] = 7'h20;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", gram_read_enable, 0);
    chk("rst_rd_addr", gram_read_address, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    run(12'h123, 13'd1, -1);
    run(12'hFFF, 13'd2, -1);
    run(12'h000, 13'd0, -1);
    run(12'h010, 13'd3, 20);
    exp_rd.push_back(12'h2AB);
    exp_tx.push_back('{{1'b0, mem[12'h2AB]}, -2});
    @(negedge clk);
    start_address = 12'h2AB;
    count = 13'd2;
    start = 1;
    @(negedge clk);
    start = 0;
    t_start = cyc;
    repeat (60) @(negedge clk);
    rst = 1;
    rx_abort = 1;
    nd = ndone;
    @(negedge clk);
    chk("rst_mid_txd", txd, 1);
    chk("rst_mid_busy", busy, 0);
    rst = 0;
    exp_rd.delete();
    exp_tx.delete();
    repeat (150) @(negedge clk);
    chk("rst_no_done", ndone, nd);
    run(12'h2AB, 13'd1, -1);
    run(12'hFF8, 13'd16, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
